// File: rtl/instr_queue_buffer.sv
// Circular instruction queue between fetch and decode: in-order push, registered
// one-cycle pop, relative-index peek, flush, occupancy and sticky error flags.
module instr_queue_buffer #(
  parameter int Instr_word_size = 32,
  parameter int bs = 16,
  localparam int PW = $clog2(bs)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [Instr_word_size-1:0] Instr_in,
  output logic                       in_ready,
  input  logic                       pop,
  output logic [Instr_word_size-1:0] Instr_out,
  output logic                       out_valid,
  input  logic [PW-1:0]              peek_index,
  output logic [Instr_word_size-1:0] peek_out,
  output logic                       peek_valid,
  output logic [PW:0]                count,
  output logic                       full,
  output logic                       empty,
  output logic                       err_overflow,
  output logic                       err_underflow
);

  localparam logic [PW:0] FULL_CNT = (PW+1)'(bs);

  logic [Instr_word_size-1:0] mem_q [bs];

  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [PW:0]                count_q, count_d;
  logic [Instr_word_size-1:0] instr_out_q, instr_out_d;
  logic                       out_valid_q, out_valid_d;
  logic [Instr_word_size-1:0] peek_out_q, peek_out_d;
  logic                       peek_valid_q, peek_valid_d;
  logic                       err_ovf_q, err_ovf_d;
  logic                       err_unf_q, err_unf_d;

  logic          full_c, empty_c;
  logic          push_acc, pop_acc;
  logic [PW-1:0] peek_addr;

  always_comb begin
    full_c    = (count_q == FULL_CNT);
    empty_c   = (count_q == '0);
    // Flush wins over both requests, so neither is accepted in that cycle.
    push_acc  = push && !full_c && !flush;
    pop_acc   = pop && !empty_c && !flush;
    peek_addr = rd_ptr_q + peek_index;
  end

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    instr_out_d  = instr_out_q;
    out_valid_d  = 1'b0;
    peek_out_d   = peek_out_q;
    peek_valid_d = 1'b0;
    err_ovf_d    = err_ovf_q;
    err_unf_d    = err_unf_q;

    if (flush) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      err_ovf_d = 1'b0;
      err_unf_d = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end
      if (pop_acc) begin
        rd_ptr_d    = rd_ptr_q + PW'(1);
        instr_out_d = mem_q[rd_ptr_q];
      end
      out_valid_d = pop_acc;

      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + (PW+1)'(1);
        2'b01:   count_d = count_q - (PW+1)'(1);
        default: count_d = count_q;
      endcase

      if (push && full_c) begin
        err_ovf_d = 1'b1;
      end
      if (pop && empty_c) begin
        err_unf_d = 1'b1;
      end

      // Peek sees pre-update state; a same-cycle push is not visible yet.
      peek_out_d   = mem_q[peek_addr];
      peek_valid_d = ({1'b0, peek_index} < count_q);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      instr_out_q  <= '0;
      out_valid_q  <= 1'b0;
      peek_out_q   <= '0;
      peek_valid_q <= 1'b0;
      err_ovf_q    <= 1'b0;
      err_unf_q    <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      instr_out_q  <= instr_out_d;
      out_valid_q  <= out_valid_d;
      peek_out_q   <= peek_out_d;
      peek_valid_q <= peek_valid_d;
      err_ovf_q    <= err_ovf_d;
      err_unf_q    <= err_unf_d;
    end
  end

  // Storage is intentionally left unreset.
  always_ff @(posedge clk) begin
    if (rst && push_acc) begin
      mem_q[wr_ptr_q] <= Instr_in;
    end
  end

  always_comb begin
    in_ready      = !full_c;
    full          = full_c;
    empty         = empty_c;
    count         = count_q;
    Instr_out     = instr_out_q;
    out_valid     = out_valid_q;
    peek_out      = peek_out_q;
    peek_valid    = peek_valid_q;
    err_overflow  = err_ovf_q;
    err_underflow = err_unf_q;
  end

endmodule

// File: tb/tb_instr_queue_buffer.sv
// Directed bench for instr_queue_buffer with a queue model and a scoreboard of
// expected pop results.
module tb_instr_queue_buffer;

  localparam int W  = 32;
  localparam int BS = 16;
  localparam int PW = 4;

  logic          clk = 1'b0;
  logic          rst, flush, push, pop;
  logic [W-1:0]  Instr_in;
  logic          in_ready;
  logic [W-1:0]  Instr_out;
  logic          out_valid;
  logic [PW-1:0] peek_index;
  logic [W-1:0]  peek_out;
  logic          peek_valid;
  logic [PW:0]   count;
  logic          full, empty, err_overflow, err_underflow;

  instr_queue_buffer #(.Instr_word_size(W), .bs(BS)) dut (
    .clk(clk), .rst(rst), .flush(flush), .push(push), .Instr_in(Instr_in),
    .in_ready(in_ready), .pop(pop), .Instr_out(Instr_out), .out_valid(out_valid),
    .peek_index(peek_index), .peek_out(peek_out), .peek_valid(peek_valid),
    .count(count), .full(full), .empty(empty),
    .err_overflow(err_overflow), .err_underflow(err_underflow)
  );

  always #5 clk = ~clk;

  logic [W-1:0] model[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] last_out;
  bit           ov_m, un_m;
  int           n_vec = 0;
  int           n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; Instr_in = '0; peek_index = '0;
    model.delete(); exp_q.delete();
    last_out = '0; ov_m = 0; un_m = 0;
    @(posedge clk); #1;
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_instr_out", Instr_out, 0);
    chk("rst_peek_out", peek_out, 0);
    chk("rst_peek_valid", peek_valid, 0);
    chk("rst_err_ovf", err_overflow, 0);
    chk("rst_err_unf", err_underflow, 0);
    chk("rst_empty", empty, 1);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
  endtask

  task automatic step(input bit p, input logic [W-1:0] d, input bit q, input bit f, input int pk);
    int           sz;
    bit           pa, qa, pk_v;
    logic [W-1:0] pk_exp;
    logic [PW-1:0] pk_idx;
    pk_idx = pk[PW-1:0];
    push = p; Instr_in = d; pop = q; flush = f; peek_index = pk_idx;
    sz     = model.size();
    pk_v   = (pk < sz) && !f;
    pk_exp = (pk < sz) ? model[pk] : '0;
    pa = 0; qa = 0;
    if (f) begin
      model.delete(); ov_m = 0; un_m = 0;
    end else begin
      pa = p && (sz < BS);
      qa = q && (sz > 0);
      if (p && sz == BS) ov_m = 1;
      if (q && sz == 0) un_m = 1;
      if (qa) exp_q.push_back(model.pop_front());
      if (pa) model.push_back(d);
    end
    @(posedge clk); #1;
    chk("out_valid", out_valid, qa);
    if (out_valid === 1'b1) begin
      chk("sb_pending", exp_q.size(), 1);
      if (exp_q.size() > 0) last_out = exp_q.pop_front();
    end
    chk("Instr_out", Instr_out, last_out);
    chk("count", count, model.size());
    chk("full", full, model.size() == BS);
    chk("empty", empty, model.size() == 0);
    chk("in_ready", in_ready, model.size() != BS);
    chk("err_overflow", err_overflow, ov_m);
    chk("err_underflow", err_underflow, un_m);
    chk("peek_valid", peek_valid, pk_v);
    if (pk_v) chk("peek_out", peek_out, pk_exp);
  endtask

  initial begin
    rst = 1'b0; push = 1'b0; pop = 1'b0; flush = 1'b0; Instr_in = '0; peek_index = '0;
    @(posedge clk);
    do_reset();

    // 1: basic in-order push/pop
    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0);
    step(1, 32'h33, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);

    // 2: fill, overflow, drain
    for (int i = 0; i < BS; i++) step(1, 32'h100 + i, 0, 0, 0);
    step(1, 32'hDEAD, 0, 0, 0);
    step(1, 32'hBEEF, 1, 0, 1);
    for (int i = 0; i < BS; i++) step(0, '0, 1, 0, 0);

    // 3: pointer wrap
    for (int i = 0; i < 12; i++) step(1, 32'h200 + i, 0, 0, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(1, 32'h300 + i, 0, 0, i);
    for (int i = 0; i < 12; i++) step(0, '0, 1, 0, 0);

    // 4: simultaneous push/pop at count==1
    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 1, 0, 0);
    step(0, '0, 1, 0, 0);

    // 5: peek look-ahead
    step(1, 32'h1, 0, 0, 0);
    step(1, 32'h2, 0, 0, 0);
    step(1, 32'h3, 0, 0, 2);
    for (int i = 0; i < 4; i++) step(0, '0, 0, 0, i);
    step(1, 32'h4, 0, 0, 3);
    step(0, '0, 0, 0, 3);

    // 6: flush priority, underflow, no-bypass, reset mid-stream
    step(1, 32'h5, 0, 0, 0);
    step(1, 32'h6, 1, 0, 1);
    step(1, 32'h7, 1, 1, 0);
    step(0, '0, 1, 0, 0);
    step(1, 32'h8, 1, 0, 0);
    step(1, 32'h9, 1, 0, 0);
    step(1, 32'hC, 0, 0, 1);
    push = 1'b1; pop = 1'b1;
    do_reset();
    step(0, '0, 1, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/instr_queue_buffer.md
Name: instr_queue_buffer

Overview:
Parametrised circular instruction queue for the fetch path, generalising the single-index instruction buffer. Fetch pushes instruction words in order; decode pops them in order with a registered one-cycle read. A relative-index peek port supports look-ahead decode, and flush, occupancy and sticky error flags support redirect and debug.

Parameters:
Instr_word_size, 32, instruction word width in bits.
bs, 16, queue depth in entries; power of two, >= 2.
PW, $clog2(bs), pointer and peek-index width (derived, not overridden).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  synchronous reset, active-low: sampled on rising clk, asserted when 0.
flush  in  1  discard all queued entries.
push  in  1  write request for Instr_in.
Instr_in  in  Instr_word_size  instruction word to enqueue.
in_ready  out  1  combinational, = !full.
pop  in  1  read-and-dequeue request for head entry.
Instr_out  out  Instr_word_size  registered head data from last accepted pop.
out_valid  out  1  registered; high for exactly one cycle after each accepted pop.
peek_index  in  PW  offset from head, 0 = head.
peek_out  out  Instr_word_size  registered entry at head+peek_index.
peek_valid  out  1  registered; peek_index < count, sampled in the request cycle.
count  out  PW+1  current occupancy, 0..bs.
full  out  1  count == bs.
empty  out  1  count == 0.
err_overflow  out  1  sticky; push attempted while full.
err_underflow  out  1  sticky; pop attempted while empty.

Behaviour:
- Reset (rst==0 at clk edge): wr_ptr, rd_ptr, count, Instr_out, out_valid, peek_out, peek_valid, err_overflow and err_underflow all go to 0. Storage array is not reset. Reset overrides all other inputs.
- Accepted push: push && !full. Stores Instr_in at wr_ptr. wr_ptr increments modulo bs; natural PW-bit wrap.
- Accepted pop: pop && !empty. Next cycle: Instr_out = mem[rd_ptr] and out_valid = 1. rd_ptr increments modulo bs.
- Pop not accepted: out_valid = 0 next cycle and Instr_out holds its previous value.
- Read latency is 1 cycle from pop to Instr_out and out_valid.
- Push and pop accepted in the same cycle: count unchanged, both pointers advance.
- Push while full: the write is dropped, state is unchanged and err_overflow is set. A simultaneous accepted pop does not make room in that cycle, because in_ready depends only on count.
- Pop while empty: ignored, err_underflow is set. No bypass: pushing into an empty queue with pop in the same cycle accepts the push and rejects the pop.
- Simultaneous push and pop when count==1 and wr_ptr!=rd_ptr: read returns the old head; the new word is stored at wr_ptr.
- Peek (every cycle): peek_out = mem[(rd_ptr+peek_index) mod bs] and peek_valid = (peek_index < count). Both use pre-update rd_ptr and count.
- Peek does not consider a same-cycle push: a slot written in cycle N is visible to peek from cycle N+1.
- Peek with peek_valid==0: peek_out is don't-care for verification; the RTL still drives the array read.
- Flush (rst==1): wr_ptr, rd_ptr and count go to 0. out_valid and peek_valid go to 0. Error flags are cleared.
- Flush has priority over push and pop in the same cycle; both are ignored and neither error flag is set.
- Instr_out and peek_out hold their values across a flush.
- count updates every cycle as count + accepted_push - accepted_pop. full and empty are combinational from count.
- Error flags are cleared only by reset or flush.

Test Plan:
1. Reset, then push 0x11,0x22,0x33 on consecutive cycles, then pop three times -> Instr_out 0x11,0x22,0x33 each one cycle after its pop; out_valid high those 3 cycles; count 3 then 0; empty=1.
2. bs=16: push 16 words 0x100..0x10F -> full=1, in_ready=0. Push 0xDEAD -> dropped, err_overflow=1. Pop 16 -> 0x100..0x10F in order, DEAD absent.
3. Wrap: push 12, pop 10, push 10 -> wr_ptr wraps to 6 (22 mod 16), rd_ptr=10, count=12. Pops return the correct order across the wrap boundary.
4. count=1 with head 0xA, push 0xB and pop same cycle -> Instr_out=0xA, count stays 1. Next pop returns 0xB.
5. Peek: queue holds 0x1,0x2,0x3. peek_index=2 -> peek_out=0x3, peek_valid=1. peek_index=3 -> peek_valid=0.
6. Flush and reset: with count=5, assert flush with push=1 and pop=1 -> count=0, out_valid=0, flags cleared. Pop on empty -> err_underflow=1. Drive rst=0 mid-stream -> next edge all outputs 0.
